data_memory_arbiter: RTL and testbench
======================================

Name: data_memory_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the 16x4 data memory unit. Ports A and B share the single memory.
- Accepts one transaction at a time under round-robin priority. Drives the memory's D_addr/D_rd/D_wr/W_data strobes and returns read data plus a completion ack to the winning requester.
- Sits between the datapath's load/store sources and the memory. The memory samples on posedge clk and its read data is registered.

Parameters:
- ADDR_W, 4, memory address width (16 words)
- DATA_W, 4, memory word width

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- a_req  input  1  requester A transaction request; held with a_wr/a_addr/a_wdata stable until a_ack
- a_wr  input  1  A: 1 = write, 0 = read
- a_addr  input  ADDR_W  A address
- a_wdata  input  DATA_W  A write data
- a_ack  output  1  A transaction complete, one-cycle pulse
- a_rdata  output  DATA_W  A read data, valid while a_ack=1 on a read
- b_req, b_wr, b_addr, b_wdata, b_ack, b_rdata  same as A, for requester B
- D_addr  output  ADDR_W  memory address
- D_rd  output  1  memory read strobe
- D_wr  output  1  memory write strobe
- W_data  output  DATA_W  memory write data
- R_data  input  DATA_W  memory read data (registered inside memory)
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, reset=1 at a rising edge):
  - state=IDLE; last_grant=B, so A wins the first tie.
  - Captured wr/addr/wdata/owner registers cleared to 0.
  - D_rd=D_wr=0, D_addr=0, W_data=0, a_ack=b_ack=0, a_rdata=b_rdata=0, busy=0.
- States: IDLE, ACCESS, READ_WAIT, ACK.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one req high: that requester wins.
  - Both high: the requester other than last_grant wins.
  - On the win edge: capture winner's wr/addr/wdata, set owner and last_grant to the winner, go to ACCESS.
  - req inputs are sampled only in IDLE.
- ACCESS (exactly one cycle):
  - D_addr=captured addr.
  - Write: D_wr=1, D_rd=0, W_data=captured wdata; next state ACK.
  - Read: D_rd=1, D_wr=0; next state READ_WAIT.
  - The memory acts on the edge that leaves ACCESS.
- READ_WAIT: R_data holds the memory word. It is loaded into the owner's rdata register on the edge leaving this state; next state ACK.
- ACK (one cycle):
  - Owner's ack=1. The other ack stays 0. Next state IDLE.
  - rdata registers hold their value until overwritten by that requester's next read. Writes leave them unchanged.
- Strobe rules:
  - D_rd and D_wr are 0 in every state except ACCESS, and are never both 1.
  - D_addr/W_data hold the captured values in every state. They are don't-care outside ACCESS but must be deterministic.
- Latency, with the request present in IDLE at cycle 0:
  - Write: ACCESS in cycle 1, memory updated at end of cycle 1, ack in cycle 2.
  - Read: ack and rdata in cycle 3.
  - Back-to-back: the next request is accepted no earlier than the IDLE cycle after ACK.
- Handshake:
  - The requester must drop req in the cycle after its ack, otherwise it is treated as a new request.
  - Request inputs are ignored outside IDLE; changes during a transaction have no effect, since values were captured.
- Fairness: when both requesters continuously re-request, grants strictly alternate, so waiting is bounded to one transaction.
- Reset mid-operation:
  - Returns to IDLE next cycle; no ack is issued for the aborted transaction.
  - A write already strobed in ACCESS before reset took effect has updated memory. A read is discarded.
- Address wrap: none; the 4-bit address covers all 16 words directly.

Test Plan:
- Reset, then a_req=1, a_wr=0, a_addr=5 -> D_rd=1 with D_addr=5 in cycle 1; a_ack=1 and a_rdata=4'b0101 in cycle 3; b_ack stays 0; busy=1 in cycles 1-3.
- b_req write, addr=3, wdata=4'b1010 -> D_wr=1, W_data=1010 in cycle 1; b_ack in cycle 2. Then B reads addr 3 -> b_rdata=1010 with b_ack.
- a_req and b_req both asserted from reset with reads of addr 1 (A) and addr 14 (B), each re-requesting after ack:
  - Grant order is A, B, A, B.
  - a_rdata=0001 and b_rdata=1110.
  - No cycle has D_rd=D_wr=1.
- A reads addr 7 while B holds req; B changes b_addr mid-transaction -> A completes with 0111; B is then served with its value sampled in IDLE.
- Reset asserted during READ_WAIT of an A read of addr 9 -> next cycle state IDLE, busy=0, no a_ack, a_rdata keeps its prior value (0 after power-on reset).
- Reset asserted during ACK of a B write (addr 2, 1100) -> memory addr 2 reads back 1100 afterward; b_ack is deasserted by reset.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - round-robin arbiter/sequencer sharing one 16x4 data memory between two requesters
module data_memory_arbiter #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_req,
   input  logic              a_wr,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_wr,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_rdata,
   output logic [ADDR_W-1:0] D_addr,
   output logic              D_rd,
   output logic              D_wr,
   output logic [DATA_W-1:0] W_data,
   input  logic [DATA_W-1:0] R_data,
   output logic              busy
);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_ACCESS    = 2'd1;
   localparam logic [1:0] S_READ_WAIT = 2'd2;
   localparam logic [1:0] S_ACK       = 2'd3;

   localparam logic OWN_A = 1'b0;
   localparam logic OWN_B = 1'b1;

   logic [1:0]        r_state;
   logic [1:0]        w_next_state;
   logic              r_last_grant;
   logic              r_owner;
   logic              r_wr;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_a_rdata;
   logic [DATA_W-1:0] r_b_rdata;

   logic              w_win;
   logic              w_win_b;
   logic              w_win_wr;
   logic [ADDR_W-1:0] w_win_addr;
   logic [DATA_W-1:0] w_win_wdata;

   // On a tie the requester that was not granted last time wins.
   always_comb begin
      w_win = a_req | b_req;
      if (a_req && b_req) begin
         w_win_b = (r_last_grant == OWN_A);
      end else begin
         w_win_b = b_req;
      end
      w_win_wr    = w_win_b ? b_wr    : a_wr;
      w_win_addr  = w_win_b ? b_addr  : a_addr;
      w_win_wdata = w_win_b ? b_wdata : a_wdata;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:      if (w_win) w_next_state = S_ACCESS;
         S_ACCESS:    w_next_state = r_wr ? S_ACK : S_READ_WAIT;
         S_READ_WAIT: w_next_state = S_ACK;
         S_ACK:       w_next_state = S_IDLE;
         default:     w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_last_grant <= OWN_B;
         r_owner      <= OWN_A;
         r_wr         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_a_rdata    <= '0;
         r_b_rdata    <= '0;
      end else begin
         r_state <= w_next_state;
         if (r_state == S_IDLE && w_win) begin
            r_wr         <= w_win_wr;
            r_addr       <= w_win_addr;
            r_wdata      <= w_win_wdata;
            r_owner      <= w_win_b;
            r_last_grant <= w_win_b;
         end
         // The memory's registered read word is valid only during READ_WAIT.
         if (r_state == S_READ_WAIT) begin
            if (r_owner == OWN_B) begin
               r_b_rdata <= R_data;
            end else begin
               r_a_rdata <= R_data;
            end
         end
      end
   end

   assign D_addr  = r_addr;
   assign W_data  = r_wdata;
   assign D_rd    = (r_state == S_ACCESS) && !r_wr;
   assign D_wr    = (r_state == S_ACCESS) &&  r_wr;
   assign a_ack   = (r_state == S_ACK) && (r_owner == OWN_A);
   assign b_ack   = (r_state == S_ACK) && (r_owner == OWN_B);
   assign a_rdata = r_a_rdata;
   assign b_rdata = r_b_rdata;
   assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb/tb_data_memory_arbiter.sv - directed table and sequence bench for data_memory_arbiter
module tb_data_memory_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       a_req, a_wr, b_req, b_wr;
   logic [3:0] a_addr, a_wdata, b_addr, b_wdata;
   logic       a_ack, b_ack;
   logic [3:0] a_rdata, b_rdata;
   logic [3:0] D_addr, W_data, R_data;
   logic       D_rd, D_wr, busy;
   logic       mem_load;
   logic [3:0] mem [16];

   int n_checks = 0;
   int n_err    = 0;
   int both_viol = 0;

   always #5 clk = ~clk;

   data_memory_arbiter #(.ADDR_W(4), .DATA_W(4)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata),
      .D_addr(D_addr), .D_rd(D_rd), .D_wr(D_wr), .W_data(W_data),
      .R_data(R_data), .busy(busy)
   );

   // Memory model: word i starts as value i, registered read data.
   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < 16; i++) mem[i] <= 4'(i);
         R_data <= 4'h0;
      end else begin
         if (D_wr) mem[D_addr] <= W_data;
         if (D_rd) R_data <= mem[D_addr];
      end
   end

   always @(negedge clk) begin
      if (D_rd === 1'b1 && D_wr === 1'b1) both_viol++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      a_req = 1'b0;
      b_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic do_txn(input string tag, input logic is_b, input logic wr,
                         input logic [3:0] addr, input logic [3:0] wdata,
                         input logic [3:0] exp_rdata, input int exp_lat);
      int   cyc;
      logic seen;
      logic other_ack;
      @(negedge clk);
      if (is_b) begin
         b_req = 1'b1; b_wr = wr; b_addr = addr; b_wdata = wdata;
      end else begin
         a_req = 1'b1; a_wr = wr; a_addr = addr; a_wdata = wdata;
      end
      cyc = 0;
      seen = 1'b0;
      other_ack = 1'b0;
      while (!seen && cyc < 10) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_daddr"}, D_addr, addr);
            chk({tag, "_drd"}, D_rd, !wr);
            chk({tag, "_dwr"}, D_wr, wr);
            if (wr) chk({tag, "_wdata"}, W_data, wdata);
         end
         if (is_b ? a_ack : b_ack) other_ack = 1'b1;
         if (is_b ? b_ack : a_ack) begin
            seen = 1'b1;
            chk({tag, "_rdata"}, is_b ? b_rdata : a_rdata, exp_rdata);
            a_req = 1'b0;
            b_req = 1'b0;
         end
      end
      a_req = 1'b0;
      b_req = 1'b0;
      chk({tag, "_ack_seen"}, seen, 1);
      chk({tag, "_latency"}, cyc, exp_lat);
      chk({tag, "_other_ack"}, other_ack, 0);
      @(negedge clk);
      chk({tag, "_idle_busy"}, busy, 0);
      chk({tag, "_idle_acks"}, {a_ack, b_ack}, 0);
   endtask

   typedef struct {
      logic       is_b;
      logic       wr;
      logic [3:0] addr;
      logic [3:0] wdata;
      logic [3:0] exp_rdata;
      int         exp_lat;
   } vec_t;

   vec_t vecs [9];

   initial begin
      int   cyc;
      int   nack;
      int   grants [4];
      logic seen;

      vecs[0] = '{1'b0, 1'b0, 4'd5,  4'h0, 4'b0101, 3};
      vecs[1] = '{1'b1, 1'b1, 4'd3,  4'hA, 4'b0000, 2};
      vecs[2] = '{1'b1, 1'b0, 4'd3,  4'h0, 4'b1010, 3};
      vecs[3] = '{1'b0, 1'b1, 4'd15, 4'h3, 4'b0101, 2};
      vecs[4] = '{1'b0, 1'b0, 4'd15, 4'h0, 4'b0011, 3};
      vecs[5] = '{1'b1, 1'b0, 4'd0,  4'h0, 4'b0000, 3};
      vecs[6] = '{1'b0, 1'b0, 4'd3,  4'h0, 4'b1010, 3};
      vecs[7] = '{1'b1, 1'b1, 4'd0,  4'hF, 4'b0000, 2};
      vecs[8] = '{1'b1, 1'b0, 4'd0,  4'h0, 4'b1111, 3};

      reset = 1'b1; mem_load = 1'b1;
      a_req = 1'b0; a_wr = 1'b0; a_addr = 4'h0; a_wdata = 4'h0;
      b_req = 1'b0; b_wr = 1'b0; b_addr = 4'h0; b_wdata = 4'h0;
      repeat (2) @(negedge clk);
      reset = 1'b0; mem_load = 1'b0;

      chk("rst_busy", busy, 0);
      chk("rst_acks", {a_ack, b_ack}, 0);
      chk("rst_strobes", {D_rd, D_wr}, 0);
      chk("rst_daddr", D_addr, 0);
      chk("rst_wdata", W_data, 0);
      chk("rst_rdata", {a_rdata, b_rdata}, 0);

      for (int i = 0; i < 9; i++) begin
         do_txn($sformatf("vec%0d", i), vecs[i].is_b, vecs[i].wr, vecs[i].addr,
                vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_lat);
      end

      // Both requesters re-request continuously: grants must alternate A,B,A,B.
      apply_reset();
      @(negedge clk);
      a_req = 1'b1; a_wr = 1'b0; a_addr = 4'd1;
      b_req = 1'b1; b_wr = 1'b0; b_addr = 4'd14;
      for (int i = 0; i < 4; i++) grants[i] = 9;
      nack = 0;
      cyc = 0;
      while (nack < 4 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (a_ack && b_ack) chk("rr_dual_ack", {a_ack, b_ack}, 2'b10);
         if (a_ack) begin
            grants[nack] = 0;
            chk($sformatf("rr_a_rdata%0d", nack), a_rdata, 4'b0001);
            nack++;
         end else if (b_ack) begin
            grants[nack] = 1;
            chk($sformatf("rr_b_rdata%0d", nack), b_rdata, 4'b1110);
            nack++;
         end
      end
      a_req = 1'b0;
      b_req = 1'b0;
      chk("rr_ack_count", nack, 4);
      chk("rr_cycles", cyc, 15);
      for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), grants[i], i % 2);

      // A read of 7 while B waits; both change their inputs mid-transaction.
      @(negedge clk);
      a_req = 1'b1; a_wr = 1'b0; a_addr = 4'd7;
      b_req = 1'b1; b_wr = 1'b0; b_addr = 4'd2;
      cyc = 0;
      seen = 1'b0;
      while (!seen && cyc < 10) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            a_addr = 4'd0;
            b_addr = 4'd9;
         end
         if (b_ack) chk("mid_b_early_ack", b_ack, 0);
         if (a_ack) begin
            seen = 1'b1;
            chk("mid_a_rdata", a_rdata, 4'b0111);
            a_req = 1'b0;
         end
      end
      chk("mid_a_latency", cyc, 3);
      seen = 1'b0;
      while (!seen && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (cyc == 5) chk("mid_b_daddr", D_addr, 9);
         if (a_ack) chk("mid_a_extra_ack", a_ack, 0);
         if (b_ack) begin
            seen = 1'b1;
            chk("mid_b_rdata", b_rdata, 4'b1001);
            b_req = 1'b0;
         end
      end
      b_req = 1'b0;
      chk("mid_b_latency", cyc, 7);

      // Reset during READ_WAIT discards the read.
      apply_reset();
      @(negedge clk);
      a_req = 1'b1; a_wr = 1'b0; a_addr = 4'd9;
      @(negedge clk);
      chk("rrw_access_drd", D_rd, 1);
      @(negedge clk);
      chk("rrw_wait_busy", busy, 1);
      chk("rrw_wait_strobes", {D_rd, D_wr}, 0);
      reset = 1'b1;
      a_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      chk("rrw_busy", busy, 0);
      chk("rrw_a_ack", a_ack, 0);
      chk("rrw_a_rdata", a_rdata, 0);
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (a_ack || busy) seen = 1'b1;
      end
      chk("rrw_quiet", seen, 0);
      chk("rrw_a_rdata_hold", a_rdata, 0);

      // Reset during ACK of a B write: the write has already landed.
      @(negedge clk);
      b_req = 1'b1; b_wr = 1'b1; b_addr = 4'd2; b_wdata = 4'hC;
      @(negedge clk);
      chk("rack_dwr", D_wr, 1);
      chk("rack_wdata", W_data, 4'hC);
      @(negedge clk);
      chk("rack_b_ack", b_ack, 1);
      reset = 1'b1;
      b_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      chk("rack_b_ack_clr", b_ack, 0);
      chk("rack_busy", busy, 0);
      do_txn("rack_readback", 1'b1, 1'b0, 4'd2, 4'h0, 4'hC, 3);

      chk("never_both_strobes", both_viol, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
